// File: rtl/upsample_2x.sv
// upsample_2x: 2x nearest-neighbour image upsampler with a single line buffer.
// Each pixel is emitted twice; even output rows come from the input, odd rows replay the buffer.
module upsample_2x #(
  parameter int D_W   = 8,
  parameter int IMG_W = 14,
  parameter int IMG_H = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] out_data,
  output logic           out_last,
  output logic           frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  typedef enum logic {FILL, REPLAY} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d, col_nx;
  logic [RW-1:0]  row_q, row_d, row_nx;
  logic           dup_q, dup_d, vld_q, vld_d, done_q;
  logic [D_W-1:0] data_q, data_d;
  logic [D_W-1:0] lbuf [IMG_W];
  logic           out_acc, in_acc, pair_done, row_end;
  // col_q is the column of the next pixel to load, so 0 while valid means the held pixel ends the row
  assign col_nx    = (col_q == CW'(IMG_W - 1)) ? '0 : col_q + CW'(1);
  assign row_nx    = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
  assign out_acc   = vld_q && out_ready;
  assign pair_done = out_acc && dup_q;
  assign row_end   = pair_done && (col_q == '0);
  assign in_ready  = !rst && (state_q == FILL) && (!vld_q || (pair_done && (col_q != '0)));
  assign in_acc    = in_valid && in_ready;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = vld_q && dup_q && (state_q == REPLAY) && (col_q == '0) && (row_q == RW'(IMG_H - 1));
  assign frame_done = done_q;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dup_d   = dup_q;
    vld_d   = vld_q;
    data_d  = data_q;
    if (out_acc) begin
      dup_d = !dup_q;
      vld_d = !dup_q;
    end
    if (in_acc) begin
      vld_d  = 1'b1;
      dup_d  = 1'b0;
      data_d = in_data;
      col_d  = col_nx;
    end
    if (row_end) begin
      state_d = (state_q == FILL) ? REPLAY : FILL;
      row_d   = (state_q == REPLAY) ? row_nx : row_q;
      vld_d   = (state_q == FILL);
      data_d  = (state_q == FILL) ? lbuf[0] : data_q;
      col_d   = (state_q == FILL) ? col_nx : col_q;
    end else if (pair_done && (state_q == REPLAY)) begin
      vld_d  = 1'b1;
      data_d = lbuf[col_q];
      col_d  = col_nx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      dup_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dup_q   <= dup_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      done_q  <= out_last && out_ready;
    end
  end
  always_ff @(posedge clk) begin
    if (in_acc) lbuf[col_q] <= in_data;
  end
endmodule
